// File: rtl/two_fsms_tick_to_level_if.sv
// Request/level bundle shared by the tick-to-level FSM pair and its driver.
interface two_fsms_tick_to_level_if;
    logic tick;
    logic Mealy_level;
    logic Moore_level;
    logic Mealy_dropped;
    logic Moore_dropped;
    logic busy;

    modport master (
        output tick,
        input  Mealy_level,
        input  Moore_level,
        input  Mealy_dropped,
        input  Moore_dropped,
        input  busy
    );

    modport slave (
        input  tick,
        output Mealy_level,
        output Moore_level,
        output Mealy_dropped,
        output Moore_dropped,
        output busy
    );
endinterface

// File: rtl/two_fsms_tick_to_level.sv
// Tick-to-level stretcher: a binary Mealy FSM and a one-hot Moore FSM run
// side by side on the same tick, each with a post-pulse low gap and drop flag.
module two_fsms_tick_to_level #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int RETRIGGER   = 1
) (
    input logic                     clk,
    input logic                     reset,
    two_fsms_tick_to_level_if.slave bus
);

    localparam int MAXV = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_M2 = (HOLD_CYCLES >= 2) ? CW'(HOLD_CYCLES - 2) : '0;
    localparam logic [CW-1:0] GAP_M1  = (GAP_CYCLES >= 1) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam bit            RETRIG  = (RETRIGGER != 0);

    typedef enum logic [1:0] {
        MEALY_IDLE,
        MEALY_HIGH,
        MEALY_GAP
    } mealy_state_e;

    typedef enum logic [2:0] {
        MOORE_IDLE = 3'b001,
        MOORE_HIGH = 3'b010,
        MOORE_GAP  = 3'b100
    } moore_state_e;

    mealy_state_e  mealy_q, mealy_d;
    moore_state_e  moore_q, moore_d;
    logic [CW-1:0] mealy_cnt_q, mealy_cnt_d;
    logic [CW-1:0] moore_cnt_q, moore_cnt_d;
    logic          mealy_drop_q, mealy_drop_d;
    logic          moore_drop_q, moore_drop_d;
    logic          mealy_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mealy_q      <= MEALY_IDLE;
            moore_q      <= MOORE_IDLE;
            mealy_cnt_q  <= '0;
            moore_cnt_q  <= '0;
            mealy_drop_q <= 1'b0;
            moore_drop_q <= 1'b0;
        end else begin
            mealy_q      <= mealy_d;
            moore_q      <= moore_d;
            mealy_cnt_q  <= mealy_cnt_d;
            moore_cnt_q  <= moore_cnt_d;
            mealy_drop_q <= mealy_drop_d;
            moore_drop_q <= moore_drop_d;
        end
    end

    // Mealy counts one less than Moore: the tick cycle itself is already high.
    always_comb begin
        mealy_d      = mealy_q;
        mealy_cnt_d  = mealy_cnt_q;
        mealy_drop_d = 1'b0;
        mealy_level  = 1'b0;
        case (mealy_q)
            MEALY_IDLE: begin
                mealy_level = bus.tick;
                if (bus.tick) begin
                    if (HOLD_CYCLES >= 2) begin
                        mealy_d     = MEALY_HIGH;
                        mealy_cnt_d = HOLD_M2;
                    end else if (GAP_CYCLES >= 1) begin
                        mealy_d     = MEALY_GAP;
                        mealy_cnt_d = GAP_M1;
                    end
                end
            end
            MEALY_HIGH: begin
                mealy_level = 1'b1;
                if (bus.tick && RETRIG) begin
                    mealy_cnt_d = HOLD_M2;
                end else begin
                    mealy_drop_d = bus.tick;
                    if (mealy_cnt_q == '0) begin
                        mealy_d     = (GAP_CYCLES >= 1) ? MEALY_GAP : MEALY_IDLE;
                        mealy_cnt_d = GAP_M1;
                    end else begin
                        mealy_cnt_d = mealy_cnt_q - ONE;
                    end
                end
            end
            MEALY_GAP: begin
                mealy_drop_d = bus.tick;
                if (mealy_cnt_q == '0) begin
                    mealy_d = MEALY_IDLE;
                end else begin
                    mealy_cnt_d = mealy_cnt_q - ONE;
                end
            end
            default: begin
                mealy_d     = MEALY_IDLE;
                mealy_cnt_d = '0;
            end
        endcase
    end

    // Any non-one-hot encoding lands in default and returns to IDLE.
    always_comb begin
        moore_d      = moore_q;
        moore_cnt_d  = moore_cnt_q;
        moore_drop_d = 1'b0;
        case (moore_q)
            MOORE_IDLE: begin
                if (bus.tick) begin
                    moore_d     = MOORE_HIGH;
                    moore_cnt_d = HOLD_M1;
                end
            end
            MOORE_HIGH: begin
                if (bus.tick && RETRIG) begin
                    moore_cnt_d = HOLD_M1;
                end else begin
                    moore_drop_d = bus.tick;
                    if (moore_cnt_q == '0) begin
                        moore_d     = (GAP_CYCLES >= 1) ? MOORE_GAP : MOORE_IDLE;
                        moore_cnt_d = GAP_M1;
                    end else begin
                        moore_cnt_d = moore_cnt_q - ONE;
                    end
                end
            end
            MOORE_GAP: begin
                moore_drop_d = bus.tick;
                if (moore_cnt_q == '0) begin
                    moore_d = MOORE_IDLE;
                end else begin
                    moore_cnt_d = moore_cnt_q - ONE;
                end
            end
            default: begin
                moore_d     = MOORE_IDLE;
                moore_cnt_d = '0;
            end
        endcase
    end

    assign bus.Mealy_level   = mealy_level & ~reset;
    assign bus.Moore_level   = (moore_q == MOORE_HIGH);
    assign bus.Mealy_dropped = mealy_drop_q;
    assign bus.Moore_dropped = moore_drop_q;
    assign bus.busy          = (mealy_q != MEALY_IDLE) | (moore_q != MOORE_IDLE);

endmodule
